host_write_credit_tracker: RTL

- Sits directly downstream of the streaming DMA's host_write AVMM master and upstream of the host write port. Fields are passed straight through.
- Counts outstanding write bursts and applies backpressure when MAX_OUTSTANDING bursts are awaiting a response.
- Counts error responses and provides a write fence: a drain handshake used before the S2M completion interrupt is raised.

---
 rtl/host_write_credit_pkg.sv | 23 ++
 rtl/host_wr_burst_counter.sv | 47 ++++
 rtl/host_write_credit_tracker.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/host_write_credit_pkg.sv
// Shared constants and types for the host write credit tracker.
// Response codes, counter widths and the fence state encoding live here.
package host_write_credit_pkg;

  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_RESERVED = 2'b01;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  localparam logic [1:0] RESP_DECERR   = 2'b11;

  localparam int OUTST_W = 8;
  localparam int ERR_W   = 16;
  localparam logic [ERR_W-1:0] ERR_MAX = 16'hFFFF;

  typedef enum logic [0:0] {
    FENCE_IDLE  = 1'b0,
    FENCE_DRAIN = 1'b1
  } fence_state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/host_wr_burst_counter.sv
// Beat tracker for AVMM write bursts: flags the first beat of a burst and
// reports whether a burst is still in progress now and after this cycle.
module host_wr_burst_counter #(
  parameter int BURST_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               beat_accept,
  input  logic [BURST_W-1:0] burstcount,
  output logic               first_beat,
  output logic               burst_busy,
  output logic               burst_busy_next
);

  logic [BURST_W-1:0] beat_cnt_r;
  logic [BURST_W-1:0] beat_cnt_s;
  logic [BURST_W-1:0] burst_len_s;

  // Next beat count: load remaining beats on a first beat, count down after.
  always_comb begin
    beat_cnt_s  = beat_cnt_r;
    burst_len_s = (burstcount == {BURST_W{1'b0}}) ? BURST_W'(1) : burstcount;
    if (beat_accept) begin
      if (beat_cnt_r == {BURST_W{1'b0}}) begin
        beat_cnt_s = burst_len_s - BURST_W'(1);
      end else begin
        beat_cnt_s = beat_cnt_r - BURST_W'(1);
      end
    end else begin
      beat_cnt_s = beat_cnt_r;
    end
  end

  // Remaining-beat register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_r <= {BURST_W{1'b0}};
    end else begin
      beat_cnt_r <= beat_cnt_s;
    end
  end

  assign first_beat      = (beat_cnt_r == {BURST_W{1'b0}});
  assign burst_busy      = !first_beat;
  assign burst_busy_next = (beat_cnt_s != {BURST_W{1'b0}});

endmodule

// File: rtl/host_write_credit_tracker.sv
// Outstanding-burst credit tracker, error counter and write fence between the
// DMA host_write master and the host port. Optional error IRQ: HOST_WR_ERR_IRQ_EN.
module host_write_credit_tracker
  import host_write_credit_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 64,
  parameter int ADDR_W          = 48,
  parameter int DATA_W          = 512,
  parameter int BURST_W         = 3
) (
  input  logic                  dma_clock_clk,
  input  logic                  reset_reset,
  input  logic [ADDR_W-1:0]     s_address,
  input  logic [DATA_W-1:0]     s_writedata,
  input  logic [DATA_W/8-1:0]   s_byteenable,
  input  logic [BURST_W-1:0]    s_burstcount,
  input  logic                  s_write,
  output logic                  s_waitrequest,
  output logic [1:0]            s_response,
  output logic                  s_writeresponsevalid,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W-1:0]     m_writedata,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic [BURST_W-1:0]    m_burstcount,
  output logic                  m_write,
  input  logic                  m_waitrequest,
  input  logic [1:0]            m_response,
  input  logic                  m_writeresponsevalid,
  input  logic                  fence_req,
  output logic                  fence_done,
`ifdef HOST_WR_ERR_IRQ_EN
  input  logic                  err_irq_clr,
  output logic                  err_irq,
`endif
  output logic [OUTST_W-1:0]    outstanding,
  output logic [ERR_W-1:0]      err_count,
  output logic                  protocol_err
);

  localparam logic [OUTST_W-1:0] MAX_OUT = OUTST_W'(MAX_OUTSTANDING);

  logic               first_beat_s;
  logic               burst_busy_s;
  logic               burst_busy_next_s;
  logic               stall_s;
  logic               beat_accept_s;
  logic               acquire_s;
  logic               release_s;
  logic               drained_s;
  logic [OUTST_W-1:0] outstanding_s;
  logic [OUTST_W-1:0] outstanding_r;
  logic [ERR_W-1:0]   err_count_r;
  logic               protocol_err_r;
  logic               fence_done_r;
  fence_state_t       fence_state_r;

  assign m_address            = s_address;
  assign m_writedata          = s_writedata;
  assign m_byteenable         = s_byteenable;
  assign m_burstcount         = s_burstcount;
  assign s_response           = m_response;
  assign s_writeresponsevalid = m_writeresponsevalid;

  // Only a burst boundary may be held back; beats inside a burst always flow.
  assign stall_s       = !burst_busy_s &&
                         ((outstanding_r == MAX_OUT) || (fence_state_r == FENCE_DRAIN));
  assign m_write       = s_write && !stall_s && !reset_reset;
  assign s_waitrequest = m_waitrequest || stall_s || reset_reset;
  assign beat_accept_s = s_write && !s_waitrequest;
  assign acquire_s     = beat_accept_s && first_beat_s;
  assign release_s     = m_writeresponsevalid;

  host_wr_burst_counter #(
    .BURST_W (BURST_W)
  ) u_burst_counter (
    .clk             (dma_clock_clk),
    .rst             (reset_reset),
    .beat_accept     (beat_accept_s),
    .burstcount      (s_burstcount),
    .first_beat      (first_beat_s),
    .burst_busy      (burst_busy_s),
    .burst_busy_next (burst_busy_next_s)
  );

  // Next outstanding count; a stray response never wraps below zero.
  always_comb begin
    outstanding_s = outstanding_r;
    case ({acquire_s, release_s})
      2'b10:   outstanding_s = outstanding_r + OUTST_W'(1);
      2'b01:   outstanding_s = (outstanding_r == OUTST_W'(0)) ? OUTST_W'(0)
                                                              : outstanding_r - OUTST_W'(1);
      default: outstanding_s = outstanding_r;
    endcase
  end

  assign drained_s = !burst_busy_next_s && (outstanding_s == OUTST_W'(0));

  // Credit, error and protocol-violation state.
  always_ff @(posedge dma_clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      outstanding_r  <= {OUTST_W{1'b0}};
      err_count_r    <= {ERR_W{1'b0}};
      protocol_err_r <= 1'b0;
    end else begin
      outstanding_r <= outstanding_s;
      if (release_s && resp_is_err(m_response) && (err_count_r != ERR_MAX)) begin
        err_count_r <= err_count_r + ERR_W'(1);
      end
      if (release_s && (outstanding_r == OUTST_W'(0))) begin
        protocol_err_r <= 1'b1;
      end
    end
  end

  // Fence FSM: completes in the request cycle when nothing is in flight.
  always_ff @(posedge dma_clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      fence_state_r <= FENCE_IDLE;
      fence_done_r  <= 1'b0;
    end else begin
      case (fence_state_r)
        FENCE_IDLE: begin
          if (fence_req && drained_s) begin
            fence_done_r <= 1'b1;
          end else if (fence_req) begin
            fence_state_r <= FENCE_DRAIN;
            fence_done_r  <= 1'b0;
          end else begin
            fence_done_r <= 1'b0;
          end
        end
        FENCE_DRAIN: begin
          if (drained_s) begin
            fence_state_r <= FENCE_IDLE;
            fence_done_r  <= 1'b1;
          end else begin
            fence_done_r <= 1'b0;
          end
        end
        default: begin
          fence_state_r <= FENCE_IDLE;
          fence_done_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HOST_WR_ERR_IRQ_EN
  logic err_irq_r;

  // Error interrupt: a new error wins over a coincident clear.
  always_ff @(posedge dma_clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      err_irq_r <= 1'b0;
    end else if (release_s && resp_is_err(m_response)) begin
      err_irq_r <= 1'b1;
    end else if (err_irq_clr) begin
      err_irq_r <= 1'b0;
    end
  end

  assign err_irq = err_irq_r;
`endif

  assign outstanding  = outstanding_r;
  assign err_count    = err_count_r;
  assign protocol_err = protocol_err_r;
  assign fence_done   = fence_done_r;

endmodule
